jtag_sync_receiver: RTL and testbench

Sits directly downstream of clock_synchronizer in the JTAG interface. Consumes the synchronized data word and request-toggle bit in the system clock domain, and waits for the multi-bit word to be stable before capturing it. Pushes captured words into a small show-ahead FIFO with a valid/ready output, and returns an acknowledge toggle to the JTAG side through the reverse synchronizer.

---
 rtl/jtag_sync_receiver_if.sv | 34 +++
 rtl/jtag_sync_receiver.sv | 200 ++++++++++++++++++++
 tb/tb_jtag_sync_receiver.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/jtag_sync_receiver_if.sv
// ============================================================================
// Module      : jtag_sync_receiver_if
// Description : Bundle of data, request/acknowledge and FIFO output signals
//               between jtag_sync_receiver and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface jtag_sync_receiver_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]             syncData;
  logic                         syncToggle;
  logic                         ackToggle;
  logic [WIDTH-1:0]             dataOut;
  logic                         dataValid;
  logic                         dataReady;
  logic [$clog2(DEPTH+1)-1:0]   fifoCount;
  logic                         overflow;
  logic                         clearOverflow;

  modport master (
    output syncData, syncToggle, dataReady, clearOverflow,
    input  ackToggle, dataOut, dataValid, fifoCount, overflow
  );

  modport slave (
    input  syncData, syncToggle, dataReady, clearOverflow,
    output ackToggle, dataOut, dataValid, fifoCount, overflow
  );
endinterface

`default_nettype wire

// File: rtl/jtag_sync_receiver.sv
// ============================================================================
// Module      : jtag_sync_receiver
// Description : Captures a synchronized JTAG word once stable, queues it in a
//               show-ahead FIFO and returns an acknowledge toggle.
//               Optional macro JTAG_SYNC_RX_DROP_ON_FULL_EN: drop on full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_sync_receiver #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 4,
  parameter int STABLE_CYCLES = 2
) (
  input  wire logic            clock,
  input  wire logic            n_reset,
  jtag_sync_receiver_if.slave  bus
);

  localparam int C_AW   = $clog2(DEPTH);
  localparam int C_CW   = $clog2(DEPTH + 1);
  localparam int C_SW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [C_SW-1:0] C_LAST = C_SW'(STABLE_CYCLES - 1);

  localparam logic [1:0] C_IDLE       = 2'd0;
  localparam logic [1:0] C_SETTLE     = 2'd1;
`ifndef JTAG_SYNC_RX_DROP_ON_FULL_EN
  localparam logic [1:0] C_WAIT_SPACE = 2'd2;
`endif

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic             r_toggle_seen;
  logic [WIDTH-1:0] r_sample;
  logic [C_SW-1:0]  r_cnt;
  logic             r_ack;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [C_AW-1:0]  r_wr_ptr;
  logic [C_AW-1:0]  r_rd_ptr;
  logic [C_AW-1:0]  w_rd_next;
  logic [C_CW-1:0]  r_count;
  logic [C_CW-1:0]  w_count_next;
  logic             r_valid;
  logic [WIDTH-1:0] r_dout;

  logic w_toggle_new, w_same, w_last, w_full, w_pop, w_space;
  logic w_take_req, w_load, w_inc, w_push, w_drop, w_ack_flip;

  assign w_toggle_new = bus.syncToggle != r_toggle_seen;
  assign w_same       = bus.syncData == r_sample;
  assign w_last       = r_cnt == C_LAST;
  assign w_full       = r_count == C_CW'(DEPTH);
  assign w_pop        = r_valid && bus.dataReady;
  // A pop on the same edge frees the slot the push needs.
  assign w_space      = !w_full || w_pop;
  assign w_rd_next    = r_rd_ptr + C_AW'(1);

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) r_state <= C_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_IDLE:   if (w_toggle_new) w_next_state = C_SETTLE;
      C_SETTLE: begin
        if (w_same && w_last) begin
`ifdef JTAG_SYNC_RX_DROP_ON_FULL_EN
          w_next_state = C_IDLE;
`else
          w_next_state = w_space ? C_IDLE : C_WAIT_SPACE;
`endif
        end
      end
`ifndef JTAG_SYNC_RX_DROP_ON_FULL_EN
      C_WAIT_SPACE: if (w_space) w_next_state = C_IDLE;
`endif
      default:  w_next_state = C_IDLE;
    endcase
  end

  always_comb begin
    w_take_req = 1'b0;
    w_load     = 1'b0;
    w_inc      = 1'b0;
    w_push     = 1'b0;
    w_drop     = 1'b0;
    w_ack_flip = 1'b0;
    case (r_state)
      C_IDLE: begin
        if (w_toggle_new) begin
          w_take_req = 1'b1;
          w_load     = 1'b1;
        end
      end
      C_SETTLE: begin
        if (!w_same) begin
          w_load = 1'b1;
        end else if (w_last) begin
          if (w_space) begin
            w_push     = 1'b1;
            w_ack_flip = 1'b1;
          end else begin
`ifdef JTAG_SYNC_RX_DROP_ON_FULL_EN
            w_drop     = 1'b1;
            w_ack_flip = 1'b1;
`endif
          end
        end else begin
          w_inc = 1'b1;
        end
      end
`ifndef JTAG_SYNC_RX_DROP_ON_FULL_EN
      C_WAIT_SPACE: begin
        if (w_space) begin
          w_push     = 1'b1;
          w_ack_flip = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_toggle_seen <= 1'b0;
      r_sample      <= '0;
      r_cnt         <= '0;
      r_ack         <= 1'b0;
    end else begin
      if (w_take_req) r_toggle_seen <= bus.syncToggle;
      if (w_load) begin
        r_sample <= bus.syncData;
        r_cnt    <= '0;
      end else if (w_inc) begin
        r_cnt <= r_cnt + C_SW'(1);
      end
      if (w_ack_flip) r_ack <= ~r_ack;
    end
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + C_CW'(1);
      2'b01:   w_count_next = r_count - C_CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= r_sample;
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_dout   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_AW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_next;
      r_count <= w_count_next;
      r_valid <= w_count_next != '0;
      // Head register: the pushed word becomes head when the FIFO is (or is
      // about to be) empty, otherwise the next stored word follows a pop.
      if (w_push && (r_count == '0 || (r_count == C_CW'(1) && w_pop)))
        r_dout <= r_sample;
      else if (w_pop && r_count > C_CW'(1))
        r_dout <= r_mem[w_rd_next];
    end
  end

`ifdef JTAG_SYNC_RX_DROP_ON_FULL_EN
  logic r_overflow;
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset)               r_overflow <= 1'b0;
    else if (w_drop)            r_overflow <= 1'b1;
    else if (bus.clearOverflow) r_overflow <= 1'b0;
  end
  assign bus.overflow = r_overflow;
`else
  logic w_unused_clr;
  assign w_unused_clr = bus.clearOverflow | w_drop;
  assign bus.overflow = 1'b0;
`endif

  assign bus.ackToggle = r_ack;
  assign bus.dataOut   = r_dout;
  assign bus.dataValid = r_valid;
  assign bus.fifoCount = r_count;

endmodule

`default_nettype wire

// File: tb/tb_jtag_sync_receiver.sv
// ============================================================================
// Module      : tb_jtag_sync_receiver
// Description : Directed bench with a scoreboard queue for popped FIFO words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtag_sync_receiver;

  logic clk;
  logic n_reset;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_q[$];
  logic tog;
  logic exp_ack;

  jtag_sync_receiver_if #(.WIDTH(32), .DEPTH(4)) bus ();

  jtag_sync_receiver #(.WIDTH(32), .DEPTH(4), .STABLE_CYCLES(2)) dut (
    .clock   (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One request whose word is pushed at the second edge after the first sample.
  task automatic req(input logic [31:0] d);
    bus.syncData = d;
    tog = ~tog;
    bus.syncToggle = tog;
    exp_q.push_back(d);
    exp_ack = ~exp_ack;
    step(3);
  endtask

  always @(negedge clk) begin
    if (n_reset && bus.dataValid && bus.dataReady) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", bus.dataOut, 32'hxxxx_xxxx);
      end else begin
        check("sb_word", bus.dataOut, exp_q.pop_front());
      end
    end
  end

  initial begin
    n_reset           = 1'b0;
    tog               = 1'b0;
    exp_ack           = 1'b0;
    bus.syncData      = 32'h0;
    bus.syncToggle    = 1'b0;
    bus.dataReady     = 1'b0;
    bus.clearOverflow = 1'b0;
    step(2);
    check("rst_valid", {31'd0, bus.dataValid}, 32'd0);
    check("rst_count", {29'd0, bus.fifoCount}, 32'd0);
    check("rst_dout",  bus.dataOut, 32'd0);
    check("rst_ack",   {31'd0, bus.ackToggle}, 32'd0);
    check("rst_ovf",   {31'd0, bus.overflow}, 32'd0);
    n_reset = 1'b1;

    // Test 1: latency of a stable word
    bus.syncData = 32'hA5A5_0001;
    tog = 1'b1;
    bus.syncToggle = tog;
    exp_q.push_back(32'hA5A5_0001);
    exp_ack = ~exp_ack;
    step(2);
    check("t1_valid_early", {31'd0, bus.dataValid}, 32'd0);
    step(1);
    check("t1_valid", {31'd0, bus.dataValid}, 32'd1);
    check("t1_dout",  bus.dataOut, 32'hA5A5_0001);
    check("t1_ack",   {31'd0, bus.ackToggle}, {31'd0, exp_ack});
    check("t1_count", {29'd0, bus.fifoCount}, 32'd1);
    bus.dataReady = 1'b1;
    step(1);
    bus.dataReady = 1'b0;
    check("t1_count_pop", {29'd0, bus.fifoCount}, 32'd0);

    // Test 2: data settling restarts the stability window
    tog = ~tog;
    bus.syncToggle = tog;
    exp_ack = ~exp_ack;
    step(1);
    bus.syncData = 32'h1234_5678;
    step(1);
    bus.syncData = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    step(2);
    check("t2_valid_early", {31'd0, bus.dataValid}, 32'd0);
    step(1);
    check("t2_valid", {31'd0, bus.dataValid}, 32'd1);
    check("t2_dout",  bus.dataOut, 32'hDEAD_BEEF);
    check("t2_count", {29'd0, bus.fifoCount}, 32'd1);
    check("t2_ack",   {31'd0, bus.ackToggle}, {31'd0, exp_ack});
    bus.dataReady = 1'b1;
    step(1);
    bus.dataReady = 1'b0;

    // Test 3/4: fill the FIFO, then a fifth request against a full FIFO
    for (int k = 1; k <= 4; k++) req(32'(k));
    check("t3_count_full", {29'd0, bus.fifoCount}, 32'd4);
    check("t3_ack4", {31'd0, bus.ackToggle}, {31'd0, exp_ack});
    bus.syncData = 32'd5;
    tog = ~tog;
    bus.syncToggle = tog;
    step(4);
    check("t3_count_blk", {29'd0, bus.fifoCount}, 32'd4);
`ifdef JTAG_SYNC_RX_DROP_ON_FULL_EN
    exp_ack = ~exp_ack;
    check("t4_ack5", {31'd0, bus.ackToggle}, {31'd0, exp_ack});
    check("t4_ovf",  {31'd0, bus.overflow}, 32'd1);
    check("t4_head", bus.dataOut, 32'd1);
    bus.clearOverflow = 1'b1;
    step(1);
    bus.clearOverflow = 1'b0;
    check("t4_ovf_clr", {31'd0, bus.overflow}, 32'd0);
`else
    check("t3_ack_stall", {31'd0, bus.ackToggle}, {31'd0, exp_ack});
    check("t3_ovf", {31'd0, bus.overflow}, 32'd0);
    exp_q.push_back(32'd5);
    exp_ack = ~exp_ack;
    bus.dataReady = 1'b1;
    step(1);
    bus.dataReady = 1'b0;
    check("t3_count_pp", {29'd0, bus.fifoCount}, 32'd4);
    check("t3_ack5", {31'd0, bus.ackToggle}, {31'd0, exp_ack});
    check("t3_head", bus.dataOut, 32'd2);
`endif

    // Test 5: continuous drain, one word per cycle
    bus.dataReady = 1'b1;
    step(3);
    check("t5_valid_mid", {31'd0, bus.dataValid}, 32'd1);
    step(1);
    bus.dataReady = 1'b0;
    check("t5_valid_end", {31'd0, bus.dataValid}, 32'd0);
    check("t5_count", {29'd0, bus.fifoCount}, 32'd0);
    check("t5_sb_empty", exp_q.size(), 32'd0);

    // Test 6: asynchronous reset mid-SETTLE with two words queued
    req(32'h11);
    req(32'h22);
    check("t6_count2", {29'd0, bus.fifoCount}, 32'd2);
    check("t6_ack_pre", {31'd0, bus.ackToggle}, {31'd0, exp_ack});
    bus.syncData = 32'h33;
    tog = ~tog;
    bus.syncToggle = tog;
    step(1);
    #2 n_reset = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, bus.dataValid}, 32'd0);
    check("t6_rst_count", {29'd0, bus.fifoCount}, 32'd0);
    check("t6_rst_ack",   {31'd0, bus.ackToggle}, 32'd0);
    exp_q.delete();
    tog = 1'b0;
    bus.syncToggle = 1'b0;
    step(2);
    n_reset = 1'b1;
    step(5);
    check("t6_post_valid", {31'd0, bus.dataValid}, 32'd0);
    check("t6_post_count", {29'd0, bus.fifoCount}, 32'd0);
    check("t6_post_ack",   {31'd0, bus.ackToggle}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
